// File: rtl/reg_chunk_pkg.sv
// Shared types and helpers for reg_chunk_reader: FSM state encoding and beat-counter sizing.
package reg_chunk_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Counter must index NUM_CHUNKS beats; a single-beat word still needs one bit.
    function automatic int counter_width(input int num_chunks);
        return (num_chunks > 1) ? $clog2(num_chunks) : 1;
    endfunction

endpackage

// File: rtl/chunk_beat_counter.sv
// Beat index for reg_chunk_reader: counts handshaked beats, saturates at the last beat, clears on demand.
module chunk_beat_counter
    import reg_chunk_pkg::*;
#(
    parameter int NUM_CHUNKS = 6,
    parameter int CW         = counter_width(NUM_CHUNKS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          clear,
    output logic [CW-1:0] count,
    output logic          terminal
);

    localparam logic [CW-1:0] LAST = CW'(NUM_CHUNKS - 1);

    assign terminal = (count == LAST);

    // Clear wins over enable so a word can restart on the same edge its last beat completes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !terminal) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/reg_chunk_reader.sv
// Captures a WIDTH-bit word and streams it as CHUNK-bit valid/ready beats, LSB chunk first.
// Define READOUT_MSB_FIRST_EN to emit the MSB chunk first instead.
module reg_chunk_reader
    import reg_chunk_pkg::*;
#(
    parameter int WIDTH = 66,
    parameter int CHUNK = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] dataIn,
    input  logic             writeEnable,
    output logic             loadReady,
    output logic [CHUNK-1:0] chunkOut,
    output logic             chunkValid,
    input  logic             chunkReady,
    output logic             lastChunk
);

    localparam int NUM_CHUNKS = WIDTH / CHUNK;
    localparam int CW         = counter_width(NUM_CHUNKS);

    generate
        if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("reg_chunk_reader: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    state_t                               state;
    logic [NUM_CHUNKS-1:0][CHUNK-1:0]     holding;
    logic [CW-1:0]                        count;
    logic [CW-1:0]                        sel;
    logic                                 terminal;
    logic                                 beat_fire;
    logic                                 word_done;
    logic                                 load;

    assign chunkValid = (state == SEND);
    assign beat_fire  = chunkValid & chunkReady;
    assign word_done  = beat_fire & terminal;
    // The final handshake frees the holding register in the same cycle, allowing zero-bubble reloads.
    assign loadReady  = (state == IDLE) | word_done;
    assign load       = writeEnable & loadReady;
    assign lastChunk  = chunkValid & terminal;

    chunk_beat_counter #(
        .NUM_CHUNKS (NUM_CHUNKS),
        .CW         (CW)
    ) u_counter (
        .clk      (clk),
        .reset    (reset),
        .enable   (beat_fire),
        .clear    (load | word_done),
        .count    (count),
        .terminal (terminal)
    );

`ifdef READOUT_MSB_FIRST_EN
    assign sel = CW'(NUM_CHUNKS - 1) - count;
`else
    assign sel = count;
`endif

    assign chunkOut = holding[sel];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            // NOTE: the holding register is reset (not left as plain storage) because chunkOut reads it directly and must be 0 out of reset.
            holding <= '0;
        end else begin
            if (load) begin
                holding <= dataIn;
                state   <= SEND;
            end else if (word_done) begin
                state   <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_reg_chunk_reader.sv
// Scoreboard bench for reg_chunk_reader: stimulus pushes expected beats, a negedge monitor compares them.
module tb_reg_chunk_reader;

    localparam int W  = 66;
    localparam int CH = 11;
    localparam int N  = W / CH;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [W-1:0]  dataIn = '0;
    logic          writeEnable = 1'b0;
    logic          loadReady;
    logic [CH-1:0] chunkOut;
    logic          chunkValid;
    logic          chunkReady = 1'b0;
    logic          lastChunk;

    reg_chunk_reader #(.WIDTH(W), .CHUNK(CH)) dut (
        .clk         (clk),
        .reset       (reset),
        .dataIn      (dataIn),
        .writeEnable (writeEnable),
        .loadReady   (loadReady),
        .chunkOut    (chunkOut),
        .chunkValid  (chunkValid),
        .chunkReady  (chunkReady),
        .lastChunk   (lastChunk)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CH-1:0] data;
        bit            last;
    } beat_t;

    beat_t        sb[$];
    int           n_checks = 0;
    int           n_fail = 0;
    bit           exp_load_ready = 1'b1;
    bit           pend = 1'b0;
    logic [W-1:0] pend_word = '0;
    bit           acc;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a word is a list of N beats, slice i being bits [i*CH +: CH].
    task automatic push_word(input logic [W-1:0] word);
        for (int i = 0; i < N; i++) begin
            beat_t        b;
            logic [W-1:0] sh;
            int           idx;
`ifdef READOUT_MSB_FIRST_EN
            idx = N - 1 - i;
`else
            idx = i;
`endif
            sh     = word >> (idx * CH);
            b.data = sh[CH-1:0];
            b.last = (i == N - 1);
            sb.push_back(b);
        end
    endtask

    // One clock cycle of stimulus; a load accepted in this cycle shows up as beats from the next cycle.
    task automatic step(input bit we, input logic [W-1:0] d, input bit rdy, output bit accepted);
        @(posedge clk);
        #1;
        if (pend) begin
            push_word(pend_word);
            pend = 1'b0;
        end
        writeEnable    = we;
        dataIn         = d;
        chunkReady     = rdy;
        exp_load_ready = (sb.size() == 0) || (sb.size() == 1 && rdy);
        accepted       = we && exp_load_ready;
        if (accepted) begin
            pend      = 1'b1;
            pend_word = d;
        end
    endtask

    task automatic drain();
        bit a;
        int guard = 0;
        while ((sb.size() != 0 || pend) && guard < 100) begin
            step(1'b0, '0, 1'b1, a);
            guard++;
        end
        check("drain_bounded", (sb.size() == 0 && !pend), 1'b1);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            check("load_ready", loadReady, exp_load_ready);
            check("chunk_valid", chunkValid, sb.size() != 0);
            if (sb.size() != 0) begin
                check("chunk_data", chunkOut, sb[0].data);
                check("last_chunk", lastChunk, sb[0].last);
                if (chunkReady) void'(sb.pop_front());
            end else begin
                check("last_idle", lastChunk, 1'b0);
            end
        end
    end

    logic [W-1:0] word_a;
    logic [W-1:0] word_b;

    initial begin
        word_a = {11'h006, 11'h005, 11'h004, 11'h003, 11'h002, 11'h001};
        word_b = {N{11'h7FF}};

        #12;
        check("rst_valid", chunkValid, 1'b0);
        check("rst_ready", loadReady, 1'b1);
        check("rst_last", lastChunk, 1'b0);
        check("rst_data", chunkOut, '0);
        #11 reset = 1'b1;

        // Basic readout with the consumer always ready.
        step(1'b1, word_a, 1'b1, acc);
        drain();

        // Backpressure on the third beat for three cycles.
        step(1'b1, word_a, 1'b1, acc);
        step(1'b0, '0, 1'b1, acc);
        step(1'b0, '0, 1'b1, acc);
        repeat (3) step(1'b0, '0, 1'b0, acc);
        drain();

        // A load attempt while busy must be ignored.
        step(1'b1, word_a, 1'b1, acc);
        step(1'b0, '0, 1'b1, acc);
        step(1'b1, '0, 1'b1, acc);
        drain();

        // Back-to-back: hold writeEnable until the last beat handshakes.
        step(1'b1, word_a, 1'b1, acc);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, word_b, 1'b1, acc);
            if (acc) break;
        end
        step(1'b0, '0, 1'b1, acc);
        drain();

        // Asynchronous reset in the middle of beat 4.
        step(1'b1, word_a, 1'b1, acc);
        repeat (4) step(1'b0, '0, 1'b1, acc);
        #2 reset = 1'b0;
        #1;
        check("arst_valid", chunkValid, 1'b0);
        check("arst_ready", loadReady, 1'b1);
        check("arst_last", lastChunk, 1'b0);
        sb.delete();
        pend           = 1'b0;
        exp_load_ready = 1'b1;
        writeEnable    = 1'b0;
        @(posedge clk);
        #3 reset = 1'b1;
        step(1'b1, {$urandom, $urandom, $urandom}, 1'b1, acc);
        drain();

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 1) == 1, {$urandom, $urandom, $urandom},
                 $urandom_range(0, 9) < 7, acc);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
